// File: rtl/accum_table_pkg.sv
// accum_table_pkg: shared types and arithmetic helpers for the accumulator table.
// Latency: n/a (types and combinational functions only).
// Backpressure: n/a.
//  Contents: state_t (IDLE/CLEAR), wide_t working type, sext_w, sat_add.
package accum_table_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Arithmetic is done in one bit more than the widest supported accumulator,
   // so a sum of two in-range operands never loses its true sign.
   localparam int unsigned MAXW = 64;

   typedef logic signed [MAXW:0] wide_t;

   typedef struct packed {
      logic            ovf;
      logic [MAXW:0]   sum;
   } sat_res_t;

   // Sign-extend the low w bits of x to the full working width.
   function automatic wide_t sext_w(input wide_t x, input int unsigned w);
      int unsigned sh;
      sh = MAXW + 1 - w;
      return (x <<< sh) >>> sh;
   endfunction

   // Signed add of two w-bit values (already sign-extended to wide_t).
   // Overflow is flagged whenever the exact sum leaves the w-bit range;
   // the result is then clamped (sat) or wrapped to w bits.
   function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                        input int unsigned w, input bit sat);
      wide_t    s;
      wide_t    hi;
      wide_t    lo;
      sat_res_t r;
      s     = a + b;
      hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo    = -hi - wide_t'(1);
      r.ovf = (s > hi) || (s < lo);
      if (r.ovf && sat) begin
         r.sum = (s > hi) ? hi : lo;
      end else begin
         r.sum = sext_w(s, w);
      end
      return r;
   endfunction

endpackage

// File: rtl/accum_lane.sv
// accum_lane: one column's add/overwrite with optional saturation.
// Latency: combinational.
// Backpressure: none; the result is consumed in the same cycle by the table.
//  Ports: accum (1: old+din, 0: sext(din)), old (stored value), din (partial sum),
//         result (new stored value), ovf (this result overflowed).
module accum_lane
   import accum_table_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned SATURATE   = 1
) (
   input  logic                  accum,
   input  logic [ACC_WIDTH-1:0]  old,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  ovf
);

   wide_t    old_w;
   wide_t    din_w;
   sat_res_t r;
   logic     unused_hi;

   // Overwrite is an add to zero; it can never overflow since ACC_WIDTH >= DATA_WIDTH.
   assign old_w  = accum ? sext_w(wide_t'(old), ACC_WIDTH) : '0;
   assign din_w  = sext_w(wide_t'(din), DATA_WIDTH);
   assign r      = sat_add(old_w, din_w, ACC_WIDTH, SATURATE != 0);
   assign result = r.sum[ACC_WIDTH-1:0];
   assign ovf    = r.ovf;

   // Upper bits are only the sign extension of result.
   assign unused_hi = ^r.sum[MAXW:ACC_WIDTH];

endmodule

// File: rtl/accum_table_mc.sv
// accum_table_mc: multi-column accumulator table with 2-stage RMW writes, forwarded RAW, clear sweep.
// Latency: write commits at the end of the cycle after accept; read data 1 cycle after rdEn.
// Backpressure: wrReady low (and rdEn/clrStart ignored) for the MAX_OUT_ROWS cycles of a clear sweep.
//  Ports: clk, reset (sync, active-low); wrEn/wrAccum/wrAddr/wrData/wrReady write side;
//         rdEn/rdAddr/rdData/rdValid read side; clrStart/busy sweep control; ovf sticky per-lane flags.
module accum_table_mc
   import accum_table_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned ACC_WIDTH    = 32,
   parameter int unsigned MAX_OUT_ROWS = 1024,
   parameter int unsigned SYS_ARR_COLS = 16,
   parameter int unsigned SATURATE     = 1,
   localparam int unsigned ADDR_W      = $clog2(MAX_OUT_ROWS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               wrEn,
   input  logic                               wrAccum,
   input  logic [ADDR_W-1:0]                  wrAddr,
   input  logic [SYS_ARR_COLS*DATA_WIDTH-1:0] wrData,
   output logic                               wrReady,
   input  logic                               rdEn,
   input  logic [ADDR_W-1:0]                  rdAddr,
   output logic [SYS_ARR_COLS*ACC_WIDTH-1:0]  rdData,
   output logic                               rdValid,
   input  logic                               clrStart,
   output logic                               busy,
   output logic [SYS_ARR_COLS-1:0]            ovf
);

   localparam int unsigned ROW_W = SYS_ARR_COLS * ACC_WIDTH;
   localparam int unsigned IN_W  = SYS_ARR_COLS * DATA_WIDTH;

   logic [ROW_W-1:0] mem [MAX_OUT_ROWS];

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] clr_ptr_q;

   logic idle;
   logic wr_acc;
   logic rd_acc;
   logic clr_acc;
   logic wr_in_range;
   logic rd_in_range;
   logic fwd;

   // Stage-1 registers: the accepted write plus the old row it modifies.
   logic                    s1_vld;
   logic                    s1_accum;
   logic                    s1_in_range;
   logic [ADDR_W-1:0]       s1_addr;
   logic [IN_W-1:0]         s1_data;
   logic [ROW_W-1:0]        old_q;
   logic [ROW_W-1:0]        s1_res;
   logic [SYS_ARR_COLS-1:0] lane_ovf;

   assign idle    = (state_q == IDLE);
   assign wrReady = idle;
   assign busy    = !idle;
   assign wr_acc  = wrEn & idle;
   assign rd_acc  = rdEn & idle;
   assign clr_acc = clrStart & idle;

   assign wr_in_range = 32'(wrAddr) < MAX_OUT_ROWS;
   assign rd_in_range = 32'(rdAddr) < MAX_OUT_ROWS;

   // RAW hazard: the row being read for stage 0 is about to be overwritten by stage 1.
   assign fwd = s1_vld && (s1_addr == wrAddr);

   for (genvar i = 0; i < SYS_ARR_COLS; i++) begin : g_lane
      accum_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH),
         .SATURATE   (SATURATE)
      ) u_lane (
         .accum  (s1_accum),
         .old    (old_q[i*ACC_WIDTH +: ACC_WIDTH]),
         .din    (s1_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .result (s1_res[i*ACC_WIDTH +: ACC_WIDTH]),
         .ovf    (lane_ovf[i])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clrStart) state_d = CLEAR;
         CLEAR:   if (clr_ptr_q == ADDR_W'(MAX_OUT_ROWS - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         clr_ptr_q <= '0;
         s1_vld    <= 1'b0;
         rdValid   <= 1'b0;
         rdData    <= '0;
         ovf       <= '0;
      end else begin
         state_q <= state_d;
         if (clr_acc) begin
            clr_ptr_q <= '0;
         end else if (!idle) begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
         end
         s1_vld  <= wr_acc;
         rdValid <= rd_acc;
         if (rd_acc) begin
            rdData <= rd_in_range ? mem[rdAddr] : '0;
         end
         // Clearing wins over an overflow from the write committing in the same cycle.
         if (clr_acc) begin
            ovf <= '0;
         end else if (s1_vld && s1_in_range) begin
            ovf <= ovf | lane_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         s1_accum    <= wrAccum;
         s1_addr     <= wrAddr;
         s1_data     <= wrData;
         s1_in_range <= wr_in_range;
         old_q       <= fwd ? s1_res : (wr_in_range ? mem[wrAddr] : '0);
      end
   end

   // Storage is never reset; writes are suppressed during reset so an aborted
   // sweep leaves untouched rows as they were.  The sweep write comes last so
   // an in-flight commit to the same row is cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (s1_vld && s1_in_range) begin
            mem[s1_addr] <= s1_res;
         end
         if (!idle) begin
            mem[clr_ptr_q] <= '0;
         end
      end
   end

endmodule
